mem_access_stage: RTL

- MIPS MEM pipeline stage. Takes EX-stage results, performs data-RAM loads and stores over a variable-latency req/ack handshake, and stalls upstream while an access is outstanding.
- Its registered outputs are exactly the write-back stage inputs: RegWrite, MemtoReg, read data, ALU result and destination register.
- Also formats sub-word load data and generates store byte enables.

---
 rtl/mem_access_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage; data-RAM loads/stores over req/ack,
// sub-word load formatting, store byte enables, stall while busy.
// Ports: in_* from EX, ram_* to data RAM, out_* to write-back,
// stall upstream, misaligned_exc/bus_err pulses with out_valid.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int RAM_AW  = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_store_data,
  input  logic [4:0]        in_dest_reg,
  output logic              stall,
  output logic              ram_req,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [31:0]       out_read_data,
  output logic [31:0]       out_alu_result,
  output logic [4:0]        out_dest_reg,
  output logic              misaligned_exc,
  output logic              bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q;

  logic        l_reg_write;
  logic        l_mem_to_reg;
  logic        l_load;
  logic [1:0]  l_size;
  logic        l_unsigned;
  logic [31:0] l_alu;
  logic [4:0]  l_dest;

  logic        is_mem;
  logic        mis;
  logic        take;
  logic        mis_ev;
  logic        start;
  logic        ack_ev;
  logic        to_ev;

  logic [1:0]  in_off;
  logic [1:0]  l_off;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign stall  = (state_q == S_WAIT);
  assign is_mem = in_mem_read | in_mem_write;
  assign in_off = in_alu_result[1:0];
  assign l_off  = l_alu[1:0];
  assign mis    = ((in_size == 2'b01) & in_off[0])
                | (in_size[1] & (in_off != 2'b00));

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    mis_ev  = 1'b0;
    start   = 1'b0;
    ack_ev  = 1'b0;
    to_ev   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            take = 1'b1;
          end else if (mis) begin
            mis_ev = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ram_ack) begin
          ack_ev  = 1'b1;
          state_d = S_IDLE;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          to_ev   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stores replicate the datum across every lane it may land in.
  always_comb begin
    st_be   = 4'b1111;
    st_data = in_store_data;
    unique case (1'b1)
      in_size == 2'b00: begin
        st_be   = 4'b0001 << in_off;
        st_data = {4{in_store_data[7:0]}};
      end
      in_size == 2'b01: begin
        st_be   = 4'b0011 << in_off;
        st_data = {2{in_store_data[15:0]}};
      end
      in_size[1]: begin
        st_be   = 4'b1111;
        st_data = in_store_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = ram_rdata[{l_off, 3'b000} +: 8];
    ld_half = ram_rdata[{l_off[1], 4'b0000} +: 16];
    ld_data = ram_rdata;
    unique case (1'b1)
      l_size == 2'b00:
        ld_data = {{24{~l_unsigned & ld_byte[7]}}, ld_byte};
      l_size == 2'b01:
        ld_data = {{16{~l_unsigned & ld_half[15]}}, ld_half};
      l_size[1]:
        ld_data = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      l_reg_write    <= 1'b0;
      l_mem_to_reg   <= 1'b0;
      l_load         <= 1'b0;
      l_size         <= '0;
      l_unsigned     <= 1'b0;
      l_alu          <= '0;
      l_dest         <= '0;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_be         <= '0;
      ram_wdata      <= '0;
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_read_data  <= '0;
      out_alu_result <= '0;
      out_dest_reg   <= '0;
      misaligned_exc <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid      <= take | mis_ev | ack_ev | to_ev;
      misaligned_exc <= mis_ev;
      bus_err        <= to_ev;
      if (state_q == S_WAIT && state_d == S_WAIT) begin
        cnt_q <= cnt_q + 32'd1;
      end else begin
        cnt_q <= '0;
      end
      if (take | mis_ev) begin
        out_reg_write  <= in_reg_write & ~mis_ev;
        out_mem_to_reg <= in_mem_to_reg;
        out_read_data  <= '0;
        out_alu_result <= in_alu_result;
        out_dest_reg   <= in_dest_reg;
      end
      if (start) begin
        l_reg_write  <= in_reg_write;
        l_mem_to_reg <= in_mem_to_reg;
        l_load       <= in_mem_read;
        l_size       <= in_size;
        l_unsigned   <= in_unsigned;
        l_alu        <= in_alu_result;
        l_dest       <= in_dest_reg;
        ram_req      <= 1'b1;
        ram_we       <= ~in_mem_read;
        ram_addr     <= in_alu_result[RAM_AW+1:2];
        ram_be       <= in_mem_read ? 4'b1111 : st_be;
        ram_wdata    <= st_data;
      end
      if (ack_ev | to_ev) begin
        ram_req        <= 1'b0;
        out_reg_write  <= l_reg_write & ack_ev;
        out_mem_to_reg <= l_mem_to_reg;
        out_read_data  <= (ack_ev & l_load) ? ld_data : 32'd0;
        out_alu_result <= l_alu;
        out_dest_reg   <= l_dest;
      end
    end
  end

endmodule
